// File: rtl/tlul_socket_1n_steer.sv
// TL-UL 1:N socket: steers host requests to one of N devices and returns in-order responses.
// Define TLUL_SOCKET_1N_ERR_RSP_EN to add an error responder at select index N.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_socket_1n_steer
  import tlul_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned NWD            = $clog2(N + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  tl_h2d_t        tl_h_i,
  output tl_d2h_t        tl_h_o,
  output tl_h2d_t        tl_d_o [N],
  input  tl_d2h_t        tl_d_i [N],
  input  logic [NWD-1:0] dev_select_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] count_reg, count_next;
  logic [NWD-1:0]  dev_select_reg, sel_eff;
  logic            hold, accept, retire;
  logic            sel_a_ready, host_a_ready;
  tl_d2h_t         rsp;
  logic [N-1:0]    dev_a_valid, dev_d_ready, dev_a_ready;

`ifdef TLUL_SOCKET_1N_ERR_RSP_EN
  assign sel_eff = dev_select_i;
`else
  // Without the error responder, out-of-range selects land on the last device.
  assign sel_eff = (dev_select_i >= NWD'(N)) ? NWD'(N - 1) : dev_select_i;
`endif

  // Stall on a target change with traffic in flight so responses stay in order.
  assign hold = ((count_reg != '0) && (sel_eff != dev_select_reg)) ||
                (count_reg == CntW'(MaxOutstanding));

  for (genvar gi = 0; gi < N; gi++) begin : g_dev
    assign dev_a_valid[gi] = tl_h_i.a_valid & (sel_eff == NWD'(gi)) & ~hold;
    assign dev_d_ready[gi] = tl_h_i.d_ready & (dev_select_reg == NWD'(gi));
    assign dev_a_ready[gi] = tl_d_i[gi].a_ready;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = dev_a_valid[i];
      tl_d_o[i].d_ready = dev_d_ready[i];
    end
  end

`ifdef TLUL_SOCKET_1N_ERR_RSP_EN
  typedef enum logic {ErrIdle, ErrResp} err_state_e;

  err_state_e  err_state_reg, err_state_next;
  logic [7:0]  err_source_reg;
  logic [1:0]  err_size_reg;
  logic        err_get_reg;
  logic        err_accept, err_a_ready;
  tl_d2h_t     err_rsp;

  assign err_accept = accept & (sel_eff == NWD'(N));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_state_reg  <= ErrIdle;
      err_source_reg <= '0;
      err_size_reg   <= '0;
      err_get_reg    <= 1'b0;
    end else begin
      err_state_reg <= err_state_next;
      if (err_accept) begin
        err_source_reg <= tl_h_i.a_source;
        err_size_reg   <= tl_h_i.a_size;
        err_get_reg    <= (tl_h_i.a_opcode == 3'd4);
      end
    end
  end

  always_comb begin
    err_state_next = err_state_reg;
    case (err_state_reg)
      ErrIdle: if (err_accept) err_state_next = ErrResp;
      ErrResp: if (tl_h_i.d_ready && (dev_select_reg == NWD'(N))) err_state_next = ErrIdle;
      default: err_state_next = ErrIdle;
    endcase
  end

  always_comb begin
    err_rsp     = '0;
    err_a_ready = (err_state_reg == ErrIdle);
    if (err_state_reg == ErrResp) begin
      err_rsp.d_valid  = 1'b1;
      err_rsp.d_error  = 1'b1;
      err_rsp.d_data   = '1;
      err_rsp.d_opcode = err_get_reg ? 3'd1 : 3'd0;
      err_rsp.d_source = err_source_reg;
      err_rsp.d_size   = err_size_reg;
    end
  end
`endif

  always_comb begin
    sel_a_ready = 1'b0;
    rsp         = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_eff == NWD'(i)) sel_a_ready = dev_a_ready[i];
      if (dev_select_reg == NWD'(i)) rsp = tl_d_i[i];
    end
`ifdef TLUL_SOCKET_1N_ERR_RSP_EN
    if (sel_eff == NWD'(N)) sel_a_ready = err_a_ready;
    if (dev_select_reg == NWD'(N)) rsp = err_rsp;
`endif
  end

  assign host_a_ready = sel_a_ready & ~hold;
  assign accept       = tl_h_i.a_valid & host_a_ready;
  assign retire       = rsp.d_valid & tl_h_i.d_ready;

  always_comb begin
    tl_h_o         = rsp;
    tl_h_o.a_ready = host_a_ready;
  end

  always_comb begin
    count_next = count_reg;
    case ({accept, retire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg      <= '0;
      dev_select_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (accept) dev_select_reg <= sel_eff;
    end
  end

`ifndef SYNTHESIS
  no_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire |-> (count_reg != '0));
  select_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_h_i.a_valid |-> (dev_select_i <= NWD'(N)));
`endif

endmodule
